vga_sync_controller: RTL
========================

# vga_sync_controller

Generates 640x480@60 Hz VGA timing from the 25 MHz pixel clock: hsync/vsync, the active-video enable and the current pixel row/column. Sits directly upstream of `rgb_controller` and drives its `en`, `row` and `column` inputs. It also provides the board-level sync pins. Frame and line start pulses let a frame-buffer reader prefetch `colour_data`.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch (pixels)
- `H_SYNC`, 96: hsync pulse width (pixels)
- `H_BP`, 48: horizontal back porch (pixels)
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch (lines)
- `V_SYNC`, 2: vsync pulse width (lines)
- `V_BP`, 33: vertical back porch (lines)
- `SYNC_POL`, 1'b0: asserted level of hsync/vsync (0 = negative sync)

Ports:
- `clk` in 1: 25 MHz pixel clock, rising-edge
- `rst` in 1: synchronous, active-low reset
- `hsync` out 1: horizontal sync
- `vsync` out 1: vertical sync
- `en` out 1: high only in active video (to `rgb_controller.en`)
- `row` out 10: active line 0..V_ACTIVE-1; 0 outside active video
- `column` out 10: active pixel 0..H_ACTIVE-1; 0 outside active video
- `frame_start` out 1: one-cycle pulse at pixel (0,0)
- `line_start` out 1: one-cycle pulse at column 0 of every active line

## Operation
- Two position counters:
  - `h_cnt` counts 0..H_TOTAL-1 (H_TOTAL = 800).
  - `v_cnt` counts 0..V_TOTAL-1 (V_TOTAL = 525).
- `v_cnt` advances only on the cycle where `h_cnt` wraps from H_TOTAL-1 to 0. `v_cnt` wraps from V_TOTAL-1 to 0.
- Per-axis FSM with states ACTIVE → FRONT_PORCH → SYNC → BACK_PORCH → ACTIVE. Each transition happens when the axis counter reaches the segment boundary:
  - H: ACTIVE 0..639, FP 640..655, SYNC 656..751, BP 752..799.
  - V: ACTIVE 0..479, FP 480..489, SYNC 490..491, BP 492..524.
- Output decode:
  - `hsync` = SYNC_POL while the H FSM is in SYNC, else ~SYNC_POL. `vsync` is decoded the same way from the V FSM.
  - `en` = (H state ACTIVE) && (V state ACTIVE).
  - `column` = h_cnt and `row` = v_cnt while `en` is high; both are 0 otherwise.
  - `frame_start` = (h_cnt==0 && v_cnt==0).
  - `line_start` = (h_cnt==0 && V state ACTIVE).
- Reset (`rst`=0 at an edge):
  - `h_cnt` loads H_TOTAL-1, `v_cnt` loads V_TOTAL-1, both FSMs load BACK_PORCH.
  - Outputs: `hsync`=`vsync`=~SYNC_POL, `en`=0, `row`=`column`=0, `frame_start`=`line_start`=0.
- Reset mid-frame aborts the frame immediately. No partial-line completion.
- Counter widths are 10 bits. H_TOTAL and V_TOTAL must be ≤ 1024 (elaboration-time check).

## Timing
- All outputs are registered, and are consistent with the counter value held in the same cycle.
- The first rising edge with `rst`=1 wraps both counters to (0,0). From that cycle: `en`=1, `row`=0, `column`=0, `frame_start`=1, `line_start`=1.
- Line period is 800 cycles (32 µs). Frame period is 420 000 cycles (16.8 ms).
- hsync asserts for exactly 96 consecutive cycles per line. vsync asserts for exactly 1600 consecutive cycles per frame, aligned to `h_cnt` wrap boundaries.
- `rgb_controller` registers r/g/b one cycle after `en`/`row`/`column`. Sync alignment for that latency is handled by the configuration option below.

## Configuration
- `VGA_SYNC_DELAY_EN` defined:
  - `hsync`/`vsync` pass through one extra register, so they lag `en`/`row`/`column` by one cycle and align with `rgb_controller` r/g/b.
  - The delay register resets to ~SYNC_POL.
  - `en`, `row`, `column` and both pulses are not delayed.
- Not defined: all outputs are aligned to the same counter value as described above.

## Structure
- Package `vga_pkg` holds:
  - the 640x480@60 timing constants and derived H_TOTAL/V_TOTAL
  - typedef enum `vga_seg_t` {ACTIVE, FRONT_PORCH, SYNC, BACK_PORCH}
  - `localparam` counter width 10
- Sub-module `vga_axis_counter` is instantiated twice (H and V).
  - Parameters: segment lengths.
  - Inputs: `clk`, `rst`, `advance`.
  - Outputs: `cnt`, `seg`, `wrap`.
  - The H instance has `advance`=1. The V instance has `advance` driven by H `wrap`.

## Test plan
- Hold `rst`=0 for 3 cycles → `hsync`=1, `vsync`=1, `en`=0, `row`=0, `column`=0, `frame_start`=0, `line_start`=0.
- Release reset → first edge gives `en`=1, (row,col)=(0,0), `frame_start`=1. `column`=639 at cycle 639. `en`=0 and `column`=0 at cycle 640.
- Measure hsync over one line → low for 96 cycles starting at h_cnt 656. Falling-edge period is 800 cycles.
- Run two frames → `vsync` low for 1600 cycles starting at line 490. `frame_start` period is 420 000 cycles. `line_start` pulses 480 times per frame.
- Assert `rst`=0 for one edge at row 100, column 300 → next cycle shows reset values. After release, restart at (0,0) with `frame_start`=1.
- With `VGA_SYNC_DELAY_EN` defined → hsync falls at h_cnt 657 and vsync falls one cycle after line 490 begins. `en`/`column` timing is unchanged.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, counter width and the per-axis segment type
// for the VGA sync generator.
package vga_pkg;
  localparam int CNT_W = 10;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef enum logic [1:0] {ACTIVE, FRONT_PORCH, SYNC, BACK_PORCH} vga_seg_t;
endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter plus ACTIVE/FP/SYNC/BP segment FSM.
// Exposes next-cycle values so the top can register outputs aligned to the counter.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACT = 640,
  parameter int FP  = 16,
  parameter int SYN = 96,
  parameter int BP  = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output vga_seg_t         seg,
  output vga_seg_t         seg_nxt,
  output logic             wrap
);
  localparam int TOTAL = ACT + FP + SYN + BP;

  if (TOTAL > (1 << CNT_W)) begin : g_total_chk
    $error("vga_axis_counter: axis total exceeds counter range");
  end

  always_comb begin
    wrap    = advance && (cnt == CNT_W'(TOTAL - 1));
    cnt_nxt = cnt;
    seg_nxt = seg;
    if (wrap)         cnt_nxt = '0;
    else if (advance) cnt_nxt = cnt + 1'b1;
    // Segment changes on the last count of the current segment.
    if (advance) begin
      case (seg)
        ACTIVE:      if (cnt == CNT_W'(ACT - 1))             seg_nxt = FRONT_PORCH;
        FRONT_PORCH: if (cnt == CNT_W'(ACT + FP - 1))        seg_nxt = SYNC;
        SYNC:        if (cnt == CNT_W'(ACT + FP + SYN - 1))  seg_nxt = BACK_PORCH;
        BACK_PORCH:  if (cnt == CNT_W'(TOTAL - 1))           seg_nxt = ACTIVE;
        default:                                             seg_nxt = BACK_PORCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= CNT_W'(TOTAL - 1);
      seg <= BACK_PORCH;
    end else begin
      cnt <= cnt_nxt;
      seg <= seg_nxt;
    end
  end
endmodule

// File: rtl/vga_sync_controller.sv
// VGA timing generator: sync pins, active-video enable, row/column and start pulses.
// Define VGA_SYNC_DELAY_EN to delay hsync/vsync one cycle to match rgb_controller.
module vga_sync_controller
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             hsync,
  output logic             vsync,
  output logic             en,
  output logic [CNT_W-1:0] row,
  output logic [CNT_W-1:0] column,
  output logic             frame_start,
  output logic             line_start
);
  logic [CNT_W-1:0] h_cnt, h_cnt_nxt, v_cnt, v_cnt_nxt;
  vga_seg_t         h_seg, h_seg_nxt, v_seg, v_seg_nxt;
  logic             h_wrap, v_wrap;
  logic             hs_n, vs_n, en_n, hs_r, vs_r;
  logic             unused_ok;

  vga_axis_counter #(.ACT(H_ACTIVE), .FP(H_FP), .SYN(H_SYNC), .BP(H_BP)) u_h (
    .clk(clk), .rst(rst), .advance(1'b1),
    .cnt(h_cnt), .cnt_nxt(h_cnt_nxt), .seg(h_seg), .seg_nxt(h_seg_nxt), .wrap(h_wrap)
  );

  vga_axis_counter #(.ACT(V_ACTIVE), .FP(V_FP), .SYN(V_SYNC), .BP(V_BP)) u_v (
    .clk(clk), .rst(rst), .advance(h_wrap),
    .cnt(v_cnt), .cnt_nxt(v_cnt_nxt), .seg(v_seg), .seg_nxt(v_seg_nxt), .wrap(v_wrap)
  );

  assign unused_ok = ^{h_cnt, v_cnt, h_seg, v_seg, v_wrap};

  // Decode from next-cycle counter state so registered outputs match the counters.
  always_comb begin
    hs_n = (h_seg_nxt == SYNC) ? SYNC_POL : ~SYNC_POL;
    vs_n = (v_seg_nxt == SYNC) ? SYNC_POL : ~SYNC_POL;
    en_n = (h_seg_nxt == ACTIVE) && (v_seg_nxt == ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hs_r        <= ~SYNC_POL;
      vs_r        <= ~SYNC_POL;
      en          <= 1'b0;
      row         <= '0;
      column      <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      hs_r        <= hs_n;
      vs_r        <= vs_n;
      en          <= en_n;
      row         <= en_n ? v_cnt_nxt : '0;
      column      <= en_n ? h_cnt_nxt : '0;
      frame_start <= (h_cnt_nxt == '0) && (v_cnt_nxt == '0);
      line_start  <= (h_cnt_nxt == '0) && (v_seg_nxt == ACTIVE);
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic hs_d, vs_d;
  always_ff @(posedge clk) begin
    if (!rst) begin
      hs_d <= ~SYNC_POL;
      vs_d <= ~SYNC_POL;
    end else begin
      hs_d <= hs_r;
      vs_d <= vs_r;
    end
  end
  assign hsync = hs_d;
  assign vsync = vs_d;
`else
  assign hsync = hs_r;
  assign vsync = vs_r;
`endif
endmodule
